codec_dac_tx: RTL and testbench
===============================

# codec_dac_tx

Serializing transmitter that carries the pedal board's processed `Signal_out` stream to the audio codec DAC over an I2S link. It generates the bit clock and left/right clock, holds one pending sample behind a valid/ready handshake, and transmits each mono sample on both channels once per frame. It is the output-side counterpart of the codec receive path that produces `Signal_in`; MCLK generation and codec register setup are outside this block.

## Interface
- `BCLK_HALF`, 8: Clk cycles per AUD_BCLK half-period; ≥2. Default gives 3.125 MHz at 50 MHz.
- `SLOT_BITS`, 32: BCLK periods per channel slot; ≥17.
- `Clk`  in  1  system clock; all logic on its rising edge.
- `RESET`  in  1  synchronous, active-low reset.
- `Sample_in`  in  16  two's-complement sample from the effects chain.
- `Sample_valid`  in  1  Sample_in is valid this cycle.
- `Sample_ready`  out  1  holding register empty; a transfer occurs when valid & ready are both high at a rising edge.
- `AUD_BCLK`  out  1  I2S bit clock.
- `AUD_DACLRCK`  out  1  0 = left slot, 1 = right slot.
- `AUD_DACDAT`  out  1  serial data, MSB first.
- `Underrun`  out  1  one-cycle pulse: frame started with no new sample.

## Operation
- Datapath: holding register `hold` with `full` flag, frame register `frame`, divider counter `div` (0..BCLK_HALF-1), and bit counter `bitc` (0..SLOT_BITS-1).
- Divider: `div` increments every cycle. When it reaches BCLK_HALF-1, it wraps to 0 and AUD_BCLK toggles. A *fall event* is a toggle from 1 to 0.
- On each fall event, `bitc` advances modulo SLOT_BITS. When it wraps from SLOT_BITS-1 to 0, AUD_DACLRCK toggles.
- Data output (I2S, one-bit delay): on a fall event where the new `bitc` is n:
  - n in 1..16: AUD_DACDAT = frame[16-n].
  - Otherwise: AUD_DACDAT = 0.
  - Both slots transmit the same `frame` value.
- Frame load: happens on a fall event where AUD_DACLRCK goes 1→0 (start of left slot).
  - If `full`: frame ← hold and `full` clears.
  - Else: `frame` keeps its last value and Underrun pulses high for exactly that cycle.
- Handshake:
  - Sample_ready = ~full, registered; it is 0 while RESET is low.
  - On transfer: hold ← Sample_in and `full` sets.
  - If a transfer and a load with empty hold occur in the same cycle, the new sample goes to `hold` for the next frame and Underrun still pulses.
  - No transfer can occur while full; valid held high while not ready is simply stalled.
- States (derived from AUD_DACLRCK and the post-reset flag): RST → RIGHT (initial, idle) → LEFT ↔ RIGHT, one transition per wrap of `bitc`.

## Timing
- Reset values, while RESET is low and in the first cycle after release:
  - AUD_BCLK = 0, AUD_DACLRCK = 1, AUD_DACDAT = 0, Underrun = 0, Sample_ready = 0.
  - `div` = 0, `bitc` = SLOT_BITS-1, `full` = 0, `frame` = 0.
- Sample_ready = 1 from cycle 1 after release (cycle 0 = first rising edge with RESET high).
- AUD_BCLK first rises at cycle BCLK_HALF and first falls at cycle 2·BCLK_HALF. That first fall event switches LRCK to 0, starting the first left slot.
- Outputs change only on fall events; the codec samples on BCLK rising edges. MSB appears at the second fall event of a slot.
- Frame period = 4·BCLK_HALF·SLOT_BITS Clk cycles (1024 by default).
- Latency: a sample accepted before a left-slot fall event has its MSB on AUD_DACDAT 2·BCLK_HALF cycles after that event.
- Reset asserted mid-frame aborts transmission in the next cycle. It returns all state to reset values and discards `hold`.

## Test plan
- Reset check: hold RESET low 5 cycles, then release. Required:
  - all outputs at reset values;
  - Sample_ready = 1 at cycle 1;
  - BCLK rises at cycle 8 and falls at cycle 16, when LRCK → 0.
- Single sample: present 0xA5C3 at cycle 2 with valid. Required:
  - left slot bits 1..16 = 1010010111000011, bits 17..31 = 0;
  - right slot identical;
  - Sample_ready 0 from cycle 3 until the frame load, then 1.
- Underrun: no sample after the 0xA5C3 frame. Required:
  - the next left-slot fall event pulses Underrun for 1 cycle;
  - both slots re-send 0xA5C3.
- Backpressure: hold valid high with 0x0001, 0x8000, 0x7FFF, each changed only after a transfer. Required:
  - exactly one transfer per frame;
  - frames carry the samples in order;
  - no Underrun.
- Reset mid-frame: pull RESET low at bit 9 of a right slot with hold full. Required:
  - AUD_DACDAT = 0 and LRCK = 1 the next cycle;
  - after release, the first frame sends 0x0000 with an Underrun pulse when no new sample is given.
- Parameter variant: BCLK_HALF = 2, SLOT_BITS = 17, send 0xFFFF. Required:
  - BCLK period 4 cycles;
  - frame 136 cycles;
  - bit 0 = 0 and bits 1..16 = 1 in each slot.

Source files
------------

// File: rtl/codec_dac_tx.sv
// rtl/codec_dac_tx.sv - I2S DAC transmitter for the processed mono sample stream
//
// Generates AUD_BCLK and AUD_DACLRCK from Clk and serializes one 16-bit
// mono sample onto both I2S channel slots each frame. A single-entry holding
// register sits behind a valid/ready handshake. The frame register is
// reloaded at the start of each left slot. If no new sample is waiting at
// that point, the last frame is resent and Underrun pulses.
//
// Ports:
//   Clk           in   system clock, rising edge
//   RESET         in   synchronous active-low reset
//   Sample_in     in   16-bit two's-complement sample
//   Sample_valid  in   Sample_in valid
//   Sample_ready  out  holding register empty (registered)
//   AUD_BCLK      out  I2S bit clock
//   AUD_DACLRCK   out  0 = left slot, 1 = right slot
//   AUD_DACDAT    out  serial data, MSB first, one BCLK after the LRCK edge
//   Underrun      out  one-cycle pulse when a frame starts with no new sample

module codec_dac_tx #(
    parameter int BCLK_HALF = 8,
    parameter int SLOT_BITS = 32
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic [15:0] Sample_in,
    input  logic        Sample_valid,
    output logic        Sample_ready,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic        Underrun
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BIT_W = $clog2(SLOT_BITS);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RIGHT = 2'd1,
        ST_LEFT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bitc_q, bitc_d;
    logic               bclk_q, bclk_d;
    logic               lrck_q, lrck_d;
    logic               dat_q, dat_d;
    logic               und_q, und_d;
    logic               ready_q, ready_d;
    logic               full_q, full_d;
    logic [15:0]        hold_q, hold_d;
    logic [15:0]        frame_q, frame_d;

    logic               wrap_div;
    logic               fall;
    logic               xfer;
    logic [BIT_W-1:0]   bit_sub;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bitc_d   = bitc_q;
        bclk_d   = bclk_q;
        lrck_d   = lrck_q;
        dat_d    = dat_q;
        und_d    = 1'b0;
        ready_d  = ready_q;
        full_d   = full_q;
        hold_d   = hold_q;
        frame_d  = frame_q;
        fall     = 1'b0;
        bit_sub  = '0;
        wrap_div = (div_q == DIV_W'(BCLK_HALF - 1));
        // ready_q is the registered ~full, so a transfer never lands on a full hold
        xfer     = Sample_valid && ready_q;

        if (state_q == ST_RST) begin
            // First cycle after reset release: everything holds reset values.
            state_d = ST_RIGHT;
        end else begin
            div_d = wrap_div ? '0 : div_q + DIV_W'(1);
            if (wrap_div) begin
                bclk_d = ~bclk_q;
                fall   = bclk_q;
            end

            if (fall) begin
                if (bitc_q == BIT_W'(SLOT_BITS - 1)) begin
                    bitc_d  = '0;
                    lrck_d  = ~lrck_q;
                    state_d = lrck_q ? ST_LEFT : ST_RIGHT;
                    // Entering the left slot starts a new frame.
                    if (lrck_q) begin
                        if (full_q) begin
                            frame_d = hold_q;
                            full_d  = 1'b0;
                        end else begin
                            und_d = 1'b1;
                        end
                    end
                end else begin
                    bitc_d = bitc_q + BIT_W'(1);
                end

                // Bit 0 of each slot is the I2S one-bit delay; bits 1..16
                // carry the sample MSB first; the remaining bits pad with 0.
                // At bit 0 the frame may be reloading, but its output is 0 anyway.
                bit_sub = BIT_W'(16) - bitc_d;
                if ((bitc_d >= BIT_W'(1)) && (bitc_d <= BIT_W'(16))) begin
                    dat_d = frame_q[bit_sub[3:0]];
                end else begin
                    dat_d = 1'b0;
                end
            end

            // A transfer coinciding with an empty-hold load lands in hold
            // for the following frame; the underrun above still stands.
            if (xfer) begin
                hold_d = Sample_in;
                full_d = 1'b1;
            end

            ready_d = ~full_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!RESET) begin
            state_q <= ST_RST;
            div_q   <= '0;
            bitc_q  <= BIT_W'(SLOT_BITS - 1);
            bclk_q  <= 1'b0;
            lrck_q  <= 1'b1;
            dat_q   <= 1'b0;
            und_q   <= 1'b0;
            ready_q <= 1'b0;
            full_q  <= 1'b0;
            hold_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bitc_q  <= bitc_d;
            bclk_q  <= bclk_d;
            lrck_q  <= lrck_d;
            dat_q   <= dat_d;
            und_q   <= und_d;
            ready_q <= ready_d;
            full_q  <= full_d;
            hold_q  <= hold_d;
            frame_q <= frame_d;
        end
    end

    assign Sample_ready = ready_q;
    assign AUD_BCLK     = bclk_q;
    assign AUD_DACLRCK  = lrck_q;
    assign AUD_DACDAT   = dat_q;
    assign Underrun     = und_q;

endmodule

// File: tb/tb_codec_dac_tx.sv
// tb/tb_codec_dac_tx.sv - self-checking bench for codec_dac_tx (default and minimum-size parameters)

module tb_codec_dac_tx;

    logic        clk = 1'b0;
    logic        rstn  [2] = '{1'b0, 1'b0};
    logic        valid [2] = '{1'b0, 1'b0};
    logic [15:0] din   [2] = '{16'h0, 16'h0};
    logic        ready [2];
    logic        bclk  [2];
    logic        lrck  [2];
    logic        dat   [2];
    logic        und   [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    codec_dac_tx #(.BCLK_HALF(8), .SLOT_BITS(32)) u_dut0 (
        .Clk(clk), .RESET(rstn[0]), .Sample_in(din[0]), .Sample_valid(valid[0]),
        .Sample_ready(ready[0]), .AUD_BCLK(bclk[0]), .AUD_DACLRCK(lrck[0]),
        .AUD_DACDAT(dat[0]), .Underrun(und[0])
    );

    codec_dac_tx #(.BCLK_HALF(2), .SLOT_BITS(17)) u_dut1 (
        .Clk(clk), .RESET(rstn[1]), .Sample_in(din[1]), .Sample_valid(valid[1]),
        .Sample_ready(ready[1]), .AUD_BCLK(bclk[1]), .AUD_DACLRCK(lrck[1]),
        .AUD_DACDAT(dat[1]), .Underrun(und[1])
    );

    function automatic int bh(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    function automatic int sb(input int i);
        return (i == 0) ? 32 : 17;
    endfunction

    // Cycle (counted from the first edge with reset released) at which bit n
    // of slot s (0 = left) of frame f is on AUD_DACDAT.
    function automatic int tnum(input int i, input int f, input int s, input int n);
        return 2 * bh(i) * (1 + f * 2 * sb(i) + s * sb(i) + n);
    endfunction

    // Inputs as seen by the DUT at each rising edge.
    logic        cap_rst   [2] = '{1'b0, 1'b0};
    logic        cap_valid [2] = '{1'b0, 1'b0};
    logic [15:0] cap_data  [2] = '{16'h0, 16'h0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            cap_rst[i]   <= rstn[i];
            cap_valid[i] <= valid[i];
            cap_data[i]  <= din[i];
        end
    end

    // Behavioural model: outputs follow from the cycle count since release
    // plus a one-deep sample buffer and the frame currently being sent.
    int          t_m     [2] = '{-1, -1};
    logic        m_full  [2] = '{1'b0, 1'b0};
    logic [15:0] m_hold  [2] = '{16'h0, 16'h0};
    logic [15:0] m_frame [2] = '{16'h0, 16'h0};
    logic        e_ready [2] = '{1'b0, 1'b0};
    logic        e_bclk  [2] = '{1'b0, 1'b0};
    logic        e_lrck  [2] = '{1'b1, 1'b1};
    logic        e_dat   [2] = '{1'b0, 1'b0};
    logic        e_und   [2] = '{1'b0, 1'b0};

    task automatic cmp(input string name, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d t=%0d got=%b want=%b", name, i, t_m[i], act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int   tt, hp, k, n;
            logic xf, ld;
            if (!cap_rst[i]) begin
                t_m[i]     = -1;
                m_full[i]  = 1'b0;
                m_hold[i]  = 16'h0;
                m_frame[i] = 16'h0;
                e_ready[i] = 1'b0;
                e_bclk[i]  = 1'b0;
                e_lrck[i]  = 1'b1;
                e_dat[i]   = 1'b0;
                e_und[i]   = 1'b0;
            end else begin
                t_m[i] = t_m[i] + 1;
                tt = t_m[i];
                hp = 2 * bh(i);
                xf = cap_valid[i] && e_ready[i];
                ld = (tt >= hp) && (tt % hp == 0) && (((tt / hp) - 1) % (2 * sb(i)) == 0);
                e_und[i] = 1'b0;
                if (ld) begin
                    if (m_full[i]) begin
                        m_frame[i] = m_hold[i];
                        m_full[i]  = 1'b0;
                    end else begin
                        e_und[i] = 1'b1;
                    end
                end
                if (xf) begin
                    m_hold[i] = cap_data[i];
                    m_full[i] = 1'b1;
                end
                e_ready[i] = (tt >= 1) && !m_full[i];
                e_bclk[i]  = ((tt / bh(i)) % 2) == 1;
                k = tt / hp;
                if (k == 0) begin
                    e_lrck[i] = 1'b1;
                    e_dat[i]  = 1'b0;
                end else begin
                    n = (k - 1) % sb(i);
                    e_lrck[i] = (((k - 1) / sb(i)) % 2) == 1;
                    e_dat[i]  = (n >= 1 && n <= 16) ? m_frame[i][16 - n] : 1'b0;
                end
            end
            cmp("ready", i, ready[i], e_ready[i]);
            cmp("bclk",  i, bclk[i],  e_bclk[i]);
            cmp("lrck",  i, lrck[i],  e_lrck[i]);
            cmp("dat",   i, dat[i],   e_dat[i]);
            cmp("underrun", i, und[i], e_und[i]);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Waits (after the model has updated) until instance i reaches cycle v.
    task automatic wait_t(input int i, input int v);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (t_m[i] == v) return;
        end
        failures++;
        $display("FAIL wait_t inst%0d target=%0d got t=%0d", i, v, t_m[i]);
    endtask

    task automatic grab(input int i, input int f, input int s, output logic [15:0] w);
        w = 16'h0;
        for (int n = 1; n <= 16; n++) begin
            wait_t(i, tnum(i, f, s, n));
            w = {w[14:0], dat[i]};
        end
    endtask

    logic [15:0] w;
    int          xt [4];
    logic [15:0] bp_vals [4] = '{16'h0001, 16'h8000, 16'h7FFF, 16'h1234};

    initial begin
        // ---------------- instance 0: defaults ----------------
        repeat (5) @(negedge clk);
        rstn[0] = 1'b1;
        wait_t(0, 0);
        chk("t0_ready", int'(ready[0]), 0);
        chk("t0_lrck", int'(lrck[0]), 1);
        wait_t(0, 1);
        chk("t1_ready", int'(ready[0]), 1);
        wait_t(0, 2);
        valid[0] = 1'b1;
        din[0]   = 16'hA5C3;
        wait_t(0, 3);
        chk("t3_ready", int'(ready[0]), 0);
        valid[0] = 1'b0;
        wait_t(0, 7);
        chk("t7_bclk", int'(bclk[0]), 0);
        wait_t(0, 8);
        chk("t8_bclk", int'(bclk[0]), 1);
        wait_t(0, 15);
        chk("t15_lrck", int'(lrck[0]), 1);
        wait_t(0, 16);
        chk("t16_bclk", int'(bclk[0]), 0);
        chk("t16_lrck", int'(lrck[0]), 0);
        chk("t16_ready", int'(ready[0]), 1);
        grab(0, 0, 0, w);
        chk("f0_left", int'(w), 16'hA5C3);
        grab(0, 0, 1, w);
        chk("f0_right", int'(w), 16'hA5C3);
        wait_t(0, 1040);
        chk("f1_underrun", int'(und[0]), 1);
        wait_t(0, 1041);
        chk("f1_underrun_end", int'(und[0]), 0);

        fork
            begin
                for (int j = 0; j < 4; j++) begin
                    int c;
                    din[0]   = bp_vals[j];
                    valid[0] = 1'b1;
                    c = 0;
                    while (!ready[0] && c < 3000) begin
                        @(negedge clk);
                        #1;
                        c++;
                    end
                    @(negedge clk);
                    #1;
                    xt[j] = t_m[0];
                end
                valid[0] = 1'b0;
            end
            begin
                logic [15:0] wb;
                grab(0, 1, 0, wb);
                chk("f1_left", int'(wb), 16'hA5C3);
                grab(0, 1, 1, wb);
                chk("f1_right", int'(wb), 16'hA5C3);
                grab(0, 2, 0, wb);
                chk("f2_left", int'(wb), 16'h0001);
                grab(0, 3, 0, wb);
                chk("f3_left", int'(wb), 16'h8000);
                grab(0, 4, 0, wb);
                chk("f4_left", int'(wb), 16'h7FFF);
            end
        join
        chk("xfer0_t", xt[0], 1042);
        chk("xfer1_t", xt[1], 2065);
        chk("xfer_spacing", xt[2] - xt[1], 1024);

        // Reset at bit 9 of the right slot of frame 4, with 0x1234 waiting in hold.
        wait_t(0, 4768);
        chk("pre_reset_dat", int'(dat[0]), 1);
        rstn[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_dat", int'(dat[0]), 0);
        chk("rst_lrck", int'(lrck[0]), 1);
        repeat (2) @(negedge clk);
        rstn[0] = 1'b1;
        wait_t(0, 16);
        chk("post_rst_underrun", int'(und[0]), 1);
        grab(0, 0, 0, w);
        chk("post_rst_left", int'(w), 16'h0000);

        // ---------------- instance 1: BCLK_HALF=2, SLOT_BITS=17 ----------------
        rstn[1] = 1'b1;
        wait_t(1, 2);
        chk("p_t2_bclk", int'(bclk[1]), 1);
        valid[1] = 1'b1;
        din[1]   = 16'hFFFF;
        wait_t(1, 3);
        valid[1] = 1'b0;
        wait_t(1, 4);
        chk("p_t4_bclk", int'(bclk[1]), 0);
        chk("p_t4_lrck", int'(lrck[1]), 0);
        chk("p_left_bit0", int'(dat[1]), 0);
        grab(1, 0, 0, w);
        chk("p_left", int'(w), 16'hFFFF);
        wait_t(1, 72);
        chk("p_right_bit0", int'(dat[1]), 0);
        chk("p_right_lrck", int'(lrck[1]), 1);
        grab(1, 0, 1, w);
        chk("p_right", int'(w), 16'hFFFF);
        wait_t(1, 140);
        chk("p_frame136_underrun", int'(und[1]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
